linear_operand_feeder: RTL and testbench

Sequencer on the operand side of `multiplier_top`: latches one weight row plus bias, then streams feature tiles into the multiplier array under valid/ready flow control. Drives the array's `weights_in`/`features`/`bias`/`ce` and emits a latency-matched result tag (`res_valid`, `res_last`) aligned with the array's `out`/`long_out`. Downstream backpressure is converted into a global `ce` stall.

---
 rtl/linear_pkg.sv | 27 ++
 rtl/tag_delay_line.sv | 41 ++++
 rtl/linear_operand_feeder.sv | 175 +++++++++++++++++
 tb/tb_linear_operand_feeder.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/linear_pkg.sv
// Shared types for the linear operand feeder: result tag, FSM states and
// beat-counter sizing.
package linear_pkg;

  // Tag that travels alongside the multiplier array pipeline.
  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  // Row sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  // Default row length limit and the matching beat-counter width.
  localparam int DEFAULT_MAX_BEATS = 256;
  localparam int BEAT_CNT_W        = $clog2(DEFAULT_MAX_BEATS);

  // Counter width able to hold 0 .. max_beats-1 (never narrower than 1 bit).
  function automatic int beat_cnt_width(input int max_beats);
    return (max_beats > 1) ? $clog2(max_beats) : 1;
  endfunction

endpackage

// File: rtl/tag_delay_line.sv
// Fixed-depth shift register for result tags. Advances only when enabled so
// it tracks the multiplier array under a global clock-enable stall.
module tag_delay_line
  import linear_pkg::*;
#(
  parameter int DEPTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  tag_t             tag_in,
  output tag_t             tag_out,
  output logic [DEPTH-1:0] valid_vec
);

  tag_t stage_reg [DEPTH];

  // Shift one stage per enabled cycle; synchronous clear drops every tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= '0;
      end
    end else if (en) begin
      stage_reg[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  // Per-stage valid flags let the owner tell when the line has emptied.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      assign valid_vec[gi] = stage_reg[gi].valid;
    end
  endgenerate

  assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/linear_operand_feeder.sv
// Operand sequencer for the multiplier array: latches one weight row and its
// bias, streams feature tiles under valid/ready, and emits a result tag that
// lines up with the array output. Downstream backpressure becomes a global
// clock-enable stall.
module linear_operand_feeder
  import linear_pkg::*;
#(
  parameter int PRECISION      = 8,
  parameter int BIAS_PRECISION = 32,
  parameter int NUM_FEATURES   = 2,
  parameter int N              = 16,
  parameter int PIPE_LATENCY   = 6,
  parameter int MAX_BEATS      = 256
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           w_valid,
  output logic                                           w_ready,
  input  logic [N-1:0][PRECISION-1:0]                    w_data,
  input  logic [BIAS_PRECISION-1:0]                      w_bias,
  input  logic                                           f_valid,
  output logic                                           f_ready,
  input  logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0]  f_data,
  input  logic                                           f_last,
  output logic [N-1:0][PRECISION-1:0]                    weights_out,
  output logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0]  features_out,
  output logic [BIAS_PRECISION-1:0]                      bias_out,
  output logic                                           ce_out,
  input  logic                                           res_ready,
  output logic                                           res_valid,
  output logic                                           res_last,
  output logic                                           overrun
);

  localparam int                CNT_W    = beat_cnt_width(MAX_BEATS);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(MAX_BEATS - 1);

  state_e              state_reg;
  state_e              state_next;
  logic [CNT_W-1:0]    beat_cnt_reg;
  logic                overrun_reg;
  tag_t                cur_tag_reg;   // tag aligned with features_out
  tag_t                tag_push;
  tag_t                res_tag;
  logic [PIPE_LATENCY-1:0] line_valid;

  logic w_fire;
  logic f_fire;
  logic forced_last;
  logic pipe_busy;
  logic drain_done;

  // A result waiting at the output with no taker freezes the whole array.
  // Reset also holds the enable low so nothing looks alive while in reset.
  assign ce_out = !rst && !(res_tag.valid && !res_ready);

  // The pipe is always empty in IDLE, so a weight load never collides with a stall.
  assign w_ready = !rst && (state_reg == ST_IDLE);
  assign f_ready = (state_reg == ST_STREAM) && ce_out;

  assign w_fire = w_valid && w_ready;
  assign f_fire = f_valid && f_ready;

  // The MAX_BEATS-th beat of a row ends it even without f_last from the source.
  assign forced_last = f_fire && !f_last && (beat_cnt_reg == LAST_CNT);

  // Tag entering the pipe this cycle; idle cycles insert bubbles.
  always_comb begin
    tag_push = '0;
    if (f_fire) begin
      tag_push.valid = 1'b1;
      tag_push.last  = f_last || forced_last;
    end
  end

  // Drain completes when the only tag left (if any) is leaving this cycle,
  // which lets the FSM reach IDLE the cycle right after the final result.
  always_comb begin
    pipe_busy = cur_tag_reg.valid;
    for (int i = 0; i < PIPE_LATENCY - 1; i++) begin
      pipe_busy = pipe_busy | line_valid[i];
    end
    drain_done = !pipe_busy && (!res_tag.valid || res_ready);
  end

  // Row sequencing: IDLE -> STREAM -> DRAIN -> IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (w_fire) begin
          state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (f_fire && (f_last || forced_last)) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (ce_out && drain_done) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, beat counter and sticky overrun flag; all frozen during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      beat_cnt_reg <= '0;
      overrun_reg  <= 1'b0;
    end else if (ce_out) begin
      state_reg <= state_next;
      if (w_fire) begin
        beat_cnt_reg <= '0;
      end else if (f_fire) begin
        beat_cnt_reg <= beat_cnt_reg + 1'b1;
      end
      if (forced_last) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  // Row operands stay constant from the load until the next row is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      weights_out <= '0;
      bias_out    <= '0;
    end else if (w_fire) begin
      weights_out <= w_data;
      bias_out    <= w_bias;
    end
  end

  // Feature register only moves on an accepted beat; bubbles keep the old tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      features_out <= '0;
    end else if (f_fire) begin
      features_out <= f_data;
    end
  end

  // First tag stage, presented in the same cycle as its features_out tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_tag_reg <= '0;
    end else if (ce_out) begin
      cur_tag_reg <= tag_push;
    end
  end

  // Remaining PIPE_LATENCY stages mirror the array's own pipeline depth.
  tag_delay_line #(
    .DEPTH (PIPE_LATENCY)
  ) u_tag_delay (
    .clk       (clk),
    .rst       (rst),
    .en        (ce_out),
    .tag_in    (cur_tag_reg),
    .tag_out   (res_tag),
    .valid_vec (line_valid)
  );

  assign res_valid = res_tag.valid;
  assign res_last  = res_tag.last;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_linear_operand_feeder.sv
// Scoreboard bench for linear_operand_feeder: drivers push expected result
// tags as beats are accepted, a monitor pops and compares on each handshake.
module tb_linear_operand_feeder;

  localparam int PRECISION      = 8;
  localparam int BIAS_PRECISION = 32;
  localparam int NUM_FEATURES   = 2;
  localparam int N              = 16;
  localparam int PIPE_LATENCY   = 6;
  localparam int MAX_BEATS      = 4;
  localparam int LAT            = PIPE_LATENCY + 1;

  typedef logic [N-1:0][PRECISION-1:0]                   wrow_t;
  typedef logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] tile_t;

  typedef struct {
    bit                        last;
    wrow_t                     w;
    logic [BIAS_PRECISION-1:0] b;
    int                        acc_cyc;
    bit                        chk_time;
  } exp_t;

  logic clk;
  logic rst;
  logic w_valid;
  logic w_ready;
  wrow_t w_data;
  logic [BIAS_PRECISION-1:0] w_bias;
  logic f_valid;
  logic f_ready;
  tile_t f_data;
  logic f_last;
  wrow_t weights_out;
  tile_t features_out;
  logic [BIAS_PRECISION-1:0] bias_out;
  logic ce_out;
  logic res_ready = 1'b1;
  logic res_valid;
  logic res_last;
  logic overrun;

  exp_t  sb_q[$];
  exp_t  mon_e;
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  bit    bp_random = 0;
  bit    model_overrun = 0;
  tile_t last_tile;
  bit    stall_req = 0;
  bit    stall_taken = 0;
  int    stall_cnt = 0;

  linear_operand_feeder #(
    .PRECISION      (PRECISION),
    .BIAS_PRECISION (BIAS_PRECISION),
    .NUM_FEATURES   (NUM_FEATURES),
    .N              (N),
    .PIPE_LATENCY   (PIPE_LATENCY),
    .MAX_BEATS      (MAX_BEATS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_data       (w_data),
    .w_bias       (w_bias),
    .f_valid      (f_valid),
    .f_ready      (f_ready),
    .f_data       (f_data),
    .f_last       (f_last),
    .weights_out  (weights_out),
    .features_out (features_out),
    .bias_out     (bias_out),
    .ce_out       (ce_out),
    .res_ready    (res_ready),
    .res_valid    (res_valid),
    .res_last     (res_last),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sole driver of res_ready: always-ready, random backpressure, or a
  // one-shot 5-cycle hold triggered when a result first shows up.
  always @(negedge clk) begin
    if (stall_req && !stall_taken && res_valid === 1'b1) begin
      stall_taken = 1;
      stall_cnt   = 5;
    end
    if (stall_cnt > 0) begin
      res_ready = 1'b0;
      stall_cnt--;
    end else if (bp_random) begin
      res_ready = ($urandom_range(0, 3) != 0);
    end else begin
      res_ready = 1'b1;
    end
  end

  // Monitor: one line per delivered result.
  always @(negedge clk) begin
    #3;
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got res_valid=1 expected no result (cycle %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        $display("[TB] result cycle %0d last=%0b (exp %0b)", cyc, res_last, mon_e.last);
        check("res_last", res_last, mon_e.last);
        check("weights_hold", weights_out, mon_e.w);
        check("bias_hold", bias_out, mon_e.b);
        if (mon_e.chk_time) check("latency", cyc - mon_e.acc_cyc, LAT);
      end
    end
  end

  task automatic load_row(input bit fixed, output wrow_t w, output logic [BIAS_PRECISION-1:0] b);
    bit ok;
    for (int e = 0; e < N; e++) w[e] = fixed ? PRECISION'(e + 1) : PRECISION'($urandom);
    b = fixed ? 32'd100 : $urandom;
    @(negedge clk);
    w_valid = 1'b1;
    w_data  = w;
    w_bias  = b;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      #2;
      if (w_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL w_accept_timeout: got no w_ready expected w_ready=1");
    end
    @(posedge clk);
    #1;
    w_valid = 1'b0;
    check("weights_load", weights_out, w);
    check("bias_load", bias_out, b);
  endtask

  task automatic send_beat(input wrow_t w, input logic [BIAS_PRECISION-1:0] b, input bit fixed,
                           input bit last, input bit chk, inout int idx, output bit ended);
    tile_t t;
    bit    ok;
    bit    forced;
    exp_t  e;
    for (int f = 0; f < NUM_FEATURES; f++)
      for (int k = 0; k < N; k++)
        t[f][k] = fixed ? PRECISION'(2) : PRECISION'($urandom);
    @(negedge clk);
    f_valid = 1'b1;
    f_data  = t;
    f_last  = last;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      #2;
      if (f_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL f_accept_timeout: got no f_ready expected f_ready=1");
      f_valid = 1'b0;
      ended = 1;
      return;
    end
    // Reference rule: the MAX_BEATS-th beat of a row always closes it.
    forced = (idx == MAX_BEATS - 1) && !last;
    if (forced) model_overrun = 1;
    e.last = last || forced;
    e.w = w;
    e.b = b;
    e.acc_cyc = cyc;
    e.chk_time = chk;
    sb_q.push_back(e);
    idx++;
    last_tile = t;
    ended = last || forced;
    @(posedge clk);
    #1;
    f_valid = 1'b0;
    check("features_out", features_out, t);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      #4;
      if (sb_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb_q.size());
    end else begin
      @(negedge clk);
      #3;
      check("idle_after_drain", w_ready, 1'b1);
    end
  endtask

  task automatic send_row(input int nbeats, input int gap, input bit fixed, input bit chk);
    wrow_t w;
    logic [BIAS_PRECISION-1:0] b;
    int idx;
    bit ended;
    load_row(fixed, w, b);
    idx = 0;
    ended = 0;
    for (int i = 0; i < nbeats && !ended; i++) begin
      if (i > 0)
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          f_valid = 1'b0;
        end
      send_beat(w, b, fixed, i == nbeats - 1, chk, idx, ended);
    end
    // Beats offered after a forced end must be refused.
    for (int i = idx; i < nbeats; i++) begin
      @(negedge clk);
      f_valid = 1'b1;
      f_last  = 1'b0;
      #2;
      check("f_ready_after_end", f_ready, 1'b0);
    end
    @(negedge clk);
    f_valid = 1'b0;
    f_last  = 1'b0;
    #3;
    check("overrun", overrun, model_overrun);
    wait_drain();
  endtask

  task automatic stall_seq();
    bit ok;
    stall_req = 1;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      #1;
      if (stall_taken) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL stall_trigger: got no result expected res_valid=1");
      return;
    end
    for (int i = 0; i < 5; i++) begin
      #2;
      check("stall_ce", ce_out, 1'b0);
      check("stall_f_ready", f_ready, 1'b0);
      check("stall_res_valid", res_valid, 1'b1);
      check("stall_res_last", res_last, 1'b0);
      check("stall_features", features_out, last_tile);
      if (i < 4) begin
        @(negedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1, "watchdog");
  end

  wrow_t rw;
  logic [BIAS_PRECISION-1:0] rb;
  int ridx;
  bit rended;
  int seen;

  initial begin
    rst = 1'b1;
    w_valid = 1'b0;
    w_data = '0;
    w_bias = '0;
    f_valid = 1'b0;
    f_data = '0;
    f_last = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    #3;
    check("rst_w_ready", w_ready, 1'b0);
    check("rst_f_ready", f_ready, 1'b0);
    check("rst_ce", ce_out, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_weights", weights_out, '0);
    check("rst_features", features_out, '0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("post_rst_w_ready", w_ready, 1'b1);
    check("post_rst_ce", ce_out, 1'b1);
    check("post_rst_f_ready", f_ready, 1'b0);

    // Single-beat row with fixed operands.
    send_row(1, 0, 1, 1);
    // Four back-to-back beats.
    send_row(4, 0, 0, 1);
    // Backpressure while beats are still streaming.
    fork
      send_row(4, 3, 0, 0);
      stall_seq();
    join
    // Alternating valid gaps.
    send_row(4, 1, 0, 1);
    // Row longer than MAX_BEATS without f_last.
    send_row(6, 0, 0, 1);
    // Random rows under random backpressure.
    bp_random = 1;
    for (int r = 0; r < 6; r++) send_row($urandom_range(1, 6), $urandom_range(0, 2), 0, 0);
    bp_random = 0;
    @(negedge clk);

    // Reset in the middle of a row with three tags in flight.
    load_row(0, rw, rb);
    ridx = 0;
    for (int i = 0; i < 3; i++) send_beat(rw, rb, 0, 0, 0, ridx, rended);
    @(negedge clk);
    f_valid = 1'b0;
    rst = 1'b1;
    sb_q.delete();
    model_overrun = 0;
    #3;
    check("midrst_w_ready", w_ready, 1'b0);
    check("midrst_ce", ce_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("after_rst_w_ready", w_ready, 1'b1);
    check("after_rst_ce", ce_out, 1'b1);
    check("after_rst_overrun", overrun, 1'b0);
    check("after_rst_weights", weights_out, '0);
    check("after_rst_bias", bias_out, '0);
    check("after_rst_features", features_out, '0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #3;
      if (res_valid === 1'b1) seen++;
    end
    check("no_result_after_rst", seen, 0);

    // Normal operation resumes after reset.
    send_row(2, 0, 0, 1);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
